// File: rtl/cpu_multicycle_if.sv
// cpu_multicycle_if: instruction and data memory req/ack bus of cpu_multicycle
interface cpu_multicycle_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  modport master (
    output imem_req, imem_addr, input imem_ack, imem_rdata,
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, input dmem_ack, dmem_rdata
  );
  modport slave (
    input imem_req, imem_addr, output imem_ack, imem_rdata,
    input dmem_req, dmem_we, dmem_addr, dmem_wdata, output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multicycle core for the 16-bit ISA with req/ack memory ports and HALT
module cpu_multicycle #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int CNT_W    = 32,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  cpu_multicycle_if.master  bus,
  output logic              halted_o,
  output logic              illegal_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [CNT_W-1:0]  retired_o
);
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam int SH_W = $clog2(DATA_W);
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, br_off, jaddr;
  logic [15:0]       ir_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, simm, alu;
  logic [DATA_W-1:0] rf_q [8];
  logic [CNT_W-1:0]  retired_q;
  logic              illegal_q, retire, nop;
  logic [2:0]        op, wr_idx;
  assign op     = ir_q[15:13];
  assign nop    = op == 3'b000 && ir_q[3];
  assign simm   = DATA_W'($signed(ir_q[6:0]));
  assign br_off = ADDR_W'($signed(ir_q[6:0]));
  assign jaddr  = ADDR_W'(ir_q[12:0]);
  assign pc_inc = pc_q + 1'b1;
  assign wr_idx = op == 3'b000 ? ir_q[6:4] : ir_q[9:7];
  // addi/lw/sw share the immediate adder; R-type selects by func[2:0]
  assign alu = op != 3'b000      ? a_q + simm :
               ir_q[2:0] == 3'd0 ? a_q + b_q :
               ir_q[2:0] == 3'd1 ? a_q - b_q :
               ir_q[2:0] == 3'd2 ? a_q & b_q :
               ir_q[2:0] == 3'd3 ? a_q | b_q :
               ir_q[2:0] == 3'd4 ? a_q ^ b_q :
               ir_q[2:0] == 3'd5 ? a_q << b_q[SH_W-1:0] :
               ir_q[2:0] == 3'd6 ? a_q >> b_q[SH_W-1:0] :
               DATA_W'($signed(a_q) < $signed(b_q));
  assign bus.imem_req   = rst_n && state_q == S_FETCH;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = rst_n && state_q == S_MEM;
  assign bus.dmem_we    = bus.dmem_req && op[0];
  assign bus.dmem_addr  = ADDR_W'(alu);
  assign bus.dmem_wdata = b_q;
  assign halted_o  = state_q == S_HALT;
  assign illegal_o = illegal_q;
  assign pc_o      = pc_q;
  assign retired_o = retired_q;
  // sequencing, PC update and retirement decided per state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = bus.imem_ack ? S_DECODE : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = op[2:1] == 2'b11 ? S_HALT :
                  op[2:1] == 2'b01 ? S_MEM :
                  (op == 3'b000 && !nop) || op == 3'b001 ? S_WB : S_FETCH;
        retire  = op == 3'b100 || op == 3'b101 || op == 3'b110 || nop;
        pc_d    = op == 3'b100 ? (a_q == b_q ? pc_inc + br_off : pc_inc) :
                  op == 3'b101 ? jaddr : nop ? pc_inc : pc_q;
      end
      S_MEM: begin
        state_d = bus.dmem_ack ? (op[0] ? S_FETCH : S_WB) : S_MEM;
        retire  = bus.dmem_ack && op[0];
        pc_d    = retire ? pc_inc : pc_q;
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
        pc_d    = pc_inc;
      end
      default: ;
    endcase
  end
  // architectural and pipeline-stage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= ADDR_W'(RESET_PC);
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      retired_q <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (state_q == S_FETCH && bus.imem_ack) ir_q <= bus.imem_rdata;
      if (state_q == S_DECODE) begin
        a_q <= rf_q[ir_q[12:10]];
        b_q <= rf_q[ir_q[9:7]];
      end
      if (state_q == S_EXEC) res_q <= alu;
      if (state_q == S_MEM && bus.dmem_ack) res_q <= bus.dmem_rdata;
      if (state_q == S_WB && wr_idx != 3'd0) rf_q[wr_idx] <= res_q;
      if (retire && !(&retired_q)) retired_q <= retired_q + 1'b1;
      if (state_q == S_EXEC && op == 3'b111) illegal_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cpu_multicycle.sv
// tb_cpu_multicycle: random and directed programs checked against an instruction-level model
module tb_cpu_multicycle;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int CW = 5;
  localparam int RMAX = (1 << CW) - 1;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } acc_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted, illegal;
  logic [AW-1:0] pc;
  logic [CW-1:0] retired;
  cpu_multicycle_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  cpu_multicycle #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .halted_o(halted), .illegal_o(illegal), .pc_o(pc), .retired_o(retired)
  );
  always #5 clk = ~clk;
  int checks = 0, fails = 0;
  logic [15:0] imem [0:65535];
  logic [DW-1:0] dmem [0:65535];
  logic [DW-1:0] mdmem [0:65535];
  logic [AW-1:0] exp_fetch [$];
  acc_t exp_acc [$];
  logic [AW+DW-1:0] got [$];
  int exp_cyc, exp_ret, waits, cyc;
  bit exp_ill, hseen, mon_en, force_ack = 1'b1;
  int iw_min, iw_max, dw_min, dw_max, iwc, dwc;
  bit ib, db, ihold, dhold;
  logic [AW-1:0] ih_a, dh_a;
  logic [DW-1:0] dh_d;
  logic dh_we;
  acc_t cur;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_store(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [AW+DW-1:0] g;
    g = got.size() > i ? got[i] : 'x;
    chk("store addr/data", 64'(g), 64'({a, d}));
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 65536; i++) imem[i] = 16'hC000;
  endtask

  // executes the program one instruction at a time from the ISA rules
  task automatic model(output int cpi, output int ret, output bit ill);
    logic [DW-1:0] r [8];
    logic [AW-1:0] p, ea;
    logic [15:0] ins;
    logic [DW-1:0] a, b, imm, sum;
    bit done;
    int sh;
    cpi = 0; ret = 0; ill = 0; done = 0; p = '0;
    for (int i = 0; i < 8; i++) r[i] = '0;
    for (int s = 0; s < 3000 && !done; s++) begin
      ins = imem[p];
      exp_fetch.push_back(p);
      a = r[ins[12:10]];
      b = r[ins[9:7]];
      imm = DW'($signed(ins[6:0]));
      sum = a + imm;
      ea = sum[AW-1:0];
      sh = int'(b % DW);
      case (ins[15:13])
        3'd0: begin
          case (ins[3:0])
            4'd0: r[ins[6:4]] = a + b;
            4'd1: r[ins[6:4]] = a - b;
            4'd2: r[ins[6:4]] = a & b;
            4'd3: r[ins[6:4]] = a | b;
            4'd4: r[ins[6:4]] = a ^ b;
            4'd5: r[ins[6:4]] = a << sh;
            4'd6: r[ins[6:4]] = a >> sh;
            4'd7: r[ins[6:4]] = ($signed(a) < $signed(b)) ? 1 : 0;
            default: ;
          endcase
          cpi += ins[3] ? 3 : 4; p = p + 1'b1; ret++;
        end
        3'd1: begin r[ins[9:7]] = sum; cpi += 4; p = p + 1'b1; ret++; end
        3'd2: begin
          r[ins[9:7]] = mdmem[ea]; exp_acc.push_back('{1'b0, ea, '0});
          cpi += 5; p = p + 1'b1; ret++;
        end
        3'd3: begin
          mdmem[ea] = b; exp_acc.push_back('{1'b1, ea, b});
          cpi += 4; p = p + 1'b1; ret++;
        end
        3'd4: begin
          p = (a == b) ? AW'(int'(p) + 1 + int'($signed(ins[6:0]))) : p + 1'b1;
          cpi += 3; ret++;
        end
        3'd5: begin p = AW'(ins[12:0]); cpi += 3; ret++; end
        3'd6: begin cpi += 3; ret++; done = 1; end
        default: begin cpi += 3; ill = 1; done = 1; end
      endcase
      r[0] = '0;
    end
  endtask

  task automatic gen();
    int len, k;
    logic [15:0] w;
    clear_imem();
    len = $urandom_range(60, 20);
    for (int i = 0; i < len; i++) begin
      k = $urandom_range(99, 0);
      w = 16'($urandom);
      if (k < 30) w[15:13] = 3'd0;
      else if (k < 50) w[15:13] = 3'd1;
      else if (k < 62) w[15:13] = 3'd2;
      else if (k < 77) w[15:13] = 3'd3;
      else if (k < 89) begin w[15:13] = 3'd4; w[6:0] = 7'($urandom_range(5, 0)); end
      else if (k < 97) w = {3'b101, 13'(i + 1 + $urandom_range(5, 0))};
      else if (k == 97) w = 16'hE000;
      else w[15:13] = 3'd0;
      imem[i] = w;
    end
  endtask

  task automatic run(input int imn, input int imx, input int dmn, input int dmx);
    int cpi, ret;
    bit ill;
    rst_n = 1'b0; mon_en = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 65536; i++) begin dmem[i] = $urandom; mdmem[i] = dmem[i]; end
    exp_fetch.delete(); exp_acc.delete(); got.delete();
    model(cpi, ret, ill);
    exp_cyc = cpi; exp_ret = ret > RMAX ? RMAX : ret; exp_ill = ill;
    iw_min = imn; iw_max = imx; dw_min = dmn; dw_max = dmx;
    waits = 0; cyc = 0; hseen = 0; ihold = 0; dhold = 0;
    @(posedge clk);
    #1 rst_n = 1'b1; mon_en = 1'b1;
    for (int t = 0; t < 4000 && !hseen; t++) @(posedge clk);
    chk("halt reached", 64'(hseen), 64'd1);
    repeat (20) @(negedge clk);
    chk("fetches left", 64'(exp_fetch.size()), 64'd0);
    chk("accesses left", 64'(exp_acc.size()), 64'd0);
    mon_en = 1'b0;
  endtask

  // memory responders with random wait states, followed by the monitor
  always @(negedge clk) begin
    if (force_ack) begin
      bus.imem_ack = 1'b1;
      bus.dmem_ack = 1'b1;
    end else begin
      if (bus.imem_req) begin
        if (!ib) begin ib = 1; iwc = $urandom_range(iw_max, iw_min); end
        bus.imem_ack = iwc == 0;
        bus.imem_rdata = imem[bus.imem_addr];
        if (iwc == 0) ib = 0; else iwc--;
      end else begin
        bus.imem_ack = 1'b0; ib = 0;
      end
      if (bus.dmem_req) begin
        if (!db) begin db = 1; dwc = $urandom_range(dw_max, dw_min); end
        bus.dmem_ack = dwc == 0;
        bus.dmem_rdata = dmem[bus.dmem_addr];
        if (bus.dmem_ack && bus.dmem_we) dmem[bus.dmem_addr] = bus.dmem_wdata;
        if (dwc == 0) db = 0; else dwc--;
      end else begin
        bus.dmem_ack = 1'b0; db = 0;
      end
    end
    if (mon_en) begin
      if (ihold) begin
        chk("imem_req held", 64'(bus.imem_req), 64'd1);
        chk("imem_addr stable", 64'(bus.imem_addr), 64'(ih_a));
      end
      if (dhold) begin
        chk("dmem_req held", 64'(bus.dmem_req), 64'd1);
        chk("dmem_we stable", 64'(bus.dmem_we), 64'(dh_we));
        chk("dmem_addr stable", 64'(bus.dmem_addr), 64'(dh_a));
        chk("dmem_wdata stable", 64'(bus.dmem_wdata), 64'(dh_d));
      end
      ihold = bus.imem_req && !bus.imem_ack; ih_a = bus.imem_addr;
      dhold = bus.dmem_req && !bus.dmem_ack; dh_a = bus.dmem_addr;
      dh_d = bus.dmem_wdata; dh_we = bus.dmem_we;
      if (ihold) waits++;
      if (dhold) waits++;
      if (bus.imem_req && bus.imem_ack) begin
        if (exp_fetch.size() == 0) chk("unexpected fetch", 64'(bus.imem_addr), 'x);
        else chk("fetch addr", 64'(bus.imem_addr), 64'(exp_fetch.pop_front()));
        chk("pc_o", 64'(pc), 64'(bus.imem_addr));
      end
      if (bus.dmem_req && bus.dmem_ack) begin
        if (bus.dmem_we) got.push_back({bus.dmem_addr, bus.dmem_wdata});
        if (exp_acc.size() == 0) chk("unexpected dmem access", 64'(bus.dmem_addr), 'x);
        else begin
          cur = exp_acc.pop_front();
          chk("dmem_we", 64'(bus.dmem_we), 64'(cur.we));
          chk("dmem_addr", 64'(bus.dmem_addr), 64'(cur.a));
          if (cur.we) chk("dmem_wdata", 64'(bus.dmem_wdata), 64'(cur.d));
        end
      end
      if (halted && !hseen) begin
        hseen = 1;
        chk("cycles to halt", 64'(cyc), 64'(exp_cyc + waits));
        chk("illegal", 64'(illegal), 64'(exp_ill));
        chk("retired", 64'(retired), 64'(exp_ret));
      end else if (hseen) begin
        chk("halted held", 64'(halted), 64'd1);
        chk("idle imem_req", 64'(bus.imem_req), 64'd0);
        chk("idle dmem_req", 64'(bus.dmem_req), 64'd0);
        chk("retired frozen", 64'(retired), 64'(exp_ret));
      end else chk("illegal while running", 64'(illegal), 64'd0);
      cyc++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iw_min = 0; iw_max = 0; dw_min = 0; dw_max = 0;
    clear_imem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset imem_req", 64'(bus.imem_req), 64'd0);
    chk("reset pc", 64'(pc), 64'd0);
    chk("reset retired", 64'(retired), 64'd0);
    chk("reset halted", 64'(halted), 64'd0);
    chk("reset illegal", 64'(illegal), 64'd0);
    chk("reset dmem_req", 64'(bus.dmem_req), 64'd0);
    chk("reset dmem_we", 64'(bus.dmem_we), 64'd0);
    chk("reset dmem_addr", 64'(bus.dmem_addr), 64'd0);
    chk("reset dmem_wdata", 64'(bus.dmem_wdata), 64'd0);
    force_ack = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("first imem_req", 64'(bus.imem_req), 64'd1);
    chk("first imem_addr", 64'(bus.imem_addr), 64'd0);
    clear_imem();
    imem[0] = 16'h2085; imem[1] = 16'h04A0; imem[2] = 16'h6103;
    run(0, 0, 0, 0);
    chk_store(0, 16'd3, 32'd10);
    run(3, 3, 0, 0);
    chk_store(0, 16'd3, 32'd10);
    clear_imem();
    imem[0] = 16'h2081; imem[1] = 16'hA004; imem[4] = 16'h84FE; imem[3] = 16'hBFFF;
    run(0, 1, 0, 0);
    clear_imem();
    imem[0] = 16'h2087; imem[1] = 16'h6089; imem[2] = 16'h4189; imem[3] = 16'h618A;
    run(0, 0, 2, 2);
    chk_store(1, 16'd10, 32'd7);
    clear_imem();
    imem[0] = 16'h20FF; imem[1] = 16'h6080; imem[2] = 16'h2101;
    imem[3] = 16'h219F; imem[4] = 16'h09C5; imem[5] = 16'h6201;
    run(1, 2, 1, 2);
    chk_store(0, 16'd0, 32'hFFFFFFFF);
    chk_store(1, 16'd1, 32'h80000000);
    clear_imem();
    run(0, 0, 0, 0);
    imem[0] = 16'hE000;
    run(0, 0, 0, 0);
    for (int n = 0; n < 30; n++) begin
      gen();
      run(0, $urandom_range(3, 0), 0, $urandom_range(3, 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multicycle successor to the single-cycle 16-bit core. It keeps the same 16-bit instruction encoding and the 8-entry register file, generalises the data and address widths, and replaces the combinational instruction and data memories with req/ack handshake ports that tolerate wait states. It adds a synchronous reset, a HALT instruction, relative branches and a retired-instruction counter. It sits between the testbench or SoC top and external instruction and data memories.

## Interface
- DATA_W, 16: register, ALU and data-memory word width (≥8).
- ADDR_W, 16: PC and memory address width (≥13).
- CNT_W, 32: width of the retired-instruction counter.
- RESET_PC, 0: PC value loaded at reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address, equal to the PC.
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  effective address.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  access complete; dmem_rdata valid in the same cycle for loads.
- dmem_rdata  in  DATA_W  load data.
- halted  out  1  core is in HALT.
- illegal  out  1  HALT was entered on opcode 111.
- pc_out  out  ADDR_W  current PC.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Decode fields:
  - opcode = [15:13], rs = [12:10], rt = [9:7], rd = [6:4], func = [3:0]
  - imm7 = [6:0], sign-extended to DATA_W for data and to ADDR_W for branch offsets
  - jaddr = [12:0], zero-extended
- Opcodes:
  - 000 R-type: rd ← rs op rt. func 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 slt (signed). func 8–15 behaves as NOP (retires, PC+1).
  - 001 addi: rt ← rs + imm.
  - 010 lw: rt ← mem[rs + imm].
  - 011 sw: mem[rs + imm] ← rt.
  - 100 beq: if rs == rt then PC ← PC + 1 + imm, else PC + 1.
  - 101 j: PC ← jaddr.
  - 110 halt: enter HALT. The instruction itself retires.
  - 111: enter HALT with illegal = 1. Does not retire.
- Arithmetic is modulo 2^DATA_W.
- Shift amount is rt[log2(DATA_W)-1:0].
- Effective addresses and the PC are taken modulo 2^ADDR_W; they wrap silently.
- Register r0 always reads 0. Writes to r0 are discarded.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: imem_req = 1. On imem_ack, latch IR → DECODE.
  - DECODE: read rs and rt into A/B → EXEC.
  - EXEC:
    - ALU ops → WB.
    - lw/sw → MEM.
    - beq/j/NOP-func: update PC, retire → FETCH.
    - halt/111 → HALT.
  - MEM: dmem_req = 1. On dmem_ack, lw latches data → WB; sw updates PC, retires → FETCH.
  - WB: write register, PC ← PC+1, retire → FETCH.
  - HALT: terminal. No requests are issued and retired is frozen. Only reset exits.
- Handshakes:
  - req is held high with addr/we/wdata stable until the cycle ack = 1 is sampled. req deasserts in the following cycle.
  - ack while req = 0 is ignored.
  - ack may be asserted in the same cycle req rises (zero-wait memory).
- retired saturates at all-ones.

## Timing
- Reset (rst_n = 0 at a rising edge):
  - state = FETCH, pc_out = RESET_PC, all registers = 0, retired = 0.
  - halted = illegal = 0.
  - imem_req = dmem_req = dmem_we = 0, dmem_addr = dmem_wdata = 0.
- Reset asserted mid-handshake abandons the transaction. A late ack after reset is ignored unless a new req is active.
- imem_req rises in the first cycle with rst_n = 1.
- Cycles per instruction with zero-wait ack:
  - R-type/addi: 4.
  - lw: 5.
  - sw: 4.
  - beq/j: 3.
  - halt: 3, then halted = 1.
- Each wait cycle on either port adds exactly 1 cycle.
- Register writes, PC update and the retired increment all occur on the same edge at instruction completion.
- A register written by instruction N is visible to instruction N+1's DECODE; no hazards exist.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles with imem_ack = 1 → imem_req = 0, pc_out = 0, retired = 0. First cycle after release: imem_req = 1, imem_addr = 0.
- Program at 0: 0x2085 (addi r1,r0,5), 0x04A0 (add r2,r1,r1), 0x6103 (sw r2,3(r0)), zero-wait → dmem_req = 1, dmem_we = 1, dmem_addr = 3, dmem_wdata = 10 in cycle 11; retired = 3 after cycle 12.
- Wait states: imem_ack delayed 3 cycles on 0x2085 → imem_req/imem_addr held stable throughout; retired increments 7 cycles after reset release.
- Branch/jump:
  - 0x84FE (beq r1,r1,-2) at PC 4 → next imem_addr = 3.
  - 0xBFFF (j) → next imem_addr = 0x1FFF.
  - Store 7 to 9, then lw r3 with dmem_ack delayed 2 cycles → r3 = 7, observed via a following sw.
- Halt: 0xC000 → halted = 1 and illegal = 0 after 3 cycles; imem_req stays 0 for ≥20 cycles; retired frozen. Opcode 0xE000 → halted = 1, illegal = 1, retired unchanged.
- DATA_W = 32: 0x20FF (addi r1,r0,-1) then sw r1 → dmem_wdata = 0xFFFFFFFF. sll of 1 by 31 → 0x80000000.
